// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor, one block per stage.
// Ports: clock, reset_n (async low), in_valid/in_ready, a, b, c_in, sub,
//        out_valid/out_ready, sum, c_out, ovf, G (word generate), P (word propagate).
module cla_pipe_adder #(
    parameter int WIDTH   = 32,
    parameter int BLOCK_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             G,
    output logic             P
);

    localparam int NB = WIDTH / BLOCK_W;

    typedef struct packed {
        logic [BLOCK_W-1:0] s;
        logic               c_out;
        logic               gb;
        logic               pb;
    } blk_t;

    // Each carry is an independent sum of products over the block's
    // bit generate/propagate terms, so no carry waits on its neighbour.
    function automatic blk_t cla_blk(
        input logic [BLOCK_W-1:0] x,
        input logic [BLOCK_W-1:0] y,
        input logic               ci
    );
        logic [BLOCK_W-1:0] g;
        logic [BLOCK_W-1:0] p;
        logic [BLOCK_W:0]   c;
        logic               gen;
        logic               prop;
        blk_t               r;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        gen  = 1'b0;
        prop = 1'b1;
        for (int i = 0; i < BLOCK_W; i++) begin
            gen  = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                gen  = gen | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = gen | (prop & ci);
        end
        r.s     = p ^ c[BLOCK_W-1:0];
        r.c_out = c[BLOCK_W];
        r.gb    = gen;
        r.pb    = prop;
        return r;
    endfunction

    logic [WIDTH-1:0] b_eff;
    assign b_eff = b ^ {WIDTH{sub}};

    // Per-stage taps shared between neighbouring stages.
    logic [NB-1:0]            adv;
    logic [NB-1:0]            vld_s;
    logic [NB-1:0]            cry_s;
    logic [NB-1:0]            g_s;
    logic [NB-1:0]            p_s;
    logic [NB-1:0][WIDTH-1:0] res_s;

    for (genvar k = 0; k < NB; k++) begin : g_stg
        logic             vld_q, vld_d;
        logic [WIDTH-1:0] res_q, res_d;
        logic             cry_q, cry_d;
        logic             g_q, g_d;
        logic             p_q, p_d;
        logic             src_v, src_c, src_g, src_p;
        logic [WIDTH-1:0] src_res;
        logic [BLOCK_W-1:0] blk_b;
        logic             ld;
        blk_t             blk;

        // res holds finished sum bits below this block and the still
        // unused A operand bits above it, so one word carries both.
        if (k == 0) begin : g_in
            assign src_v   = in_valid;
            assign src_c   = c_in ^ sub;
            assign src_g   = 1'b0;
            assign src_p   = 1'b1;
            assign src_res = a;
            assign blk_b   = b_eff[BLOCK_W-1:0];
        end else begin : g_in
            assign src_v   = vld_s[k-1];
            assign src_c   = cry_s[k-1];
            assign src_g   = g_s[k-1];
            assign src_p   = p_s[k-1];
            assign src_res = res_s[k-1];
            assign blk_b   = g_stg[k-1].g_hi.bh_q[BLOCK_W-1:0];
        end

        if (k == NB - 1) begin : g_adv
            assign adv[k] = ~vld_q | out_ready;
        end else begin : g_adv
            assign adv[k] = ~vld_q | adv[k+1];
        end

        assign ld  = adv[k] & src_v;
        assign blk = cla_blk(src_res[k*BLOCK_W +: BLOCK_W], blk_b, src_c);

        always_comb begin
            vld_d = adv[k] ? src_v : vld_q;
            res_d = res_q;
            cry_d = cry_q;
            g_d   = g_q;
            p_d   = p_q;
            if (ld) begin
                res_d                       = src_res;
                res_d[k*BLOCK_W +: BLOCK_W] = blk.s;
                cry_d                       = blk.c_out;
                g_d                         = blk.gb | (blk.pb & src_g);
                p_d                         = blk.pb & src_p;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                vld_q <= 1'b0;
                res_q <= '0;
                cry_q <= 1'b0;
                g_q   <= 1'b0;
                p_q   <= 1'b0;
            end else begin
                vld_q <= vld_d;
                res_q <= res_d;
                cry_q <= cry_d;
                g_q   <= g_d;
                p_q   <= p_d;
            end
        end

        assign vld_s[k] = vld_q;
        assign res_s[k] = res_q;
        assign cry_s[k] = cry_q;
        assign g_s[k]   = g_q;
        assign p_s[k]   = p_q;

        // Effective-B bits not yet consumed; shrinks by one block per stage.
        if (k < NB - 1) begin : g_hi
            logic [WIDTH-(k+1)*BLOCK_W-1:0] bh_q, bh_d;
            if (k == 0) begin : g_src
                assign bh_d = ld ? b_eff[WIDTH-1:BLOCK_W] : bh_q;
            end else begin : g_src
                assign bh_d = ld ?
                    g_stg[k-1].g_hi.bh_q[WIDTH-k*BLOCK_W-1:BLOCK_W] : bh_q;
            end
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    bh_q <= '0;
                end else begin
                    bh_q <= bh_d;
                end
            end
        end

        // Carry into the MSB equals p[msb] ^ s[msb], so overflow needs
        // only the top operand bits, the top sum bit and carry out.
        if (k == NB - 1) begin : g_ovf
            logic ovf_q, ovf_d;
            assign ovf_d = ld ? (src_res[WIDTH-1] ^ blk_b[BLOCK_W-1]
                                 ^ blk.s[BLOCK_W-1] ^ blk.c_out)
                              : ovf_q;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_s[NB-1];
    assign sum       = res_s[NB-1];
    assign c_out     = cry_s[NB-1];
    assign G         = g_s[NB-1];
    assign P         = p_s[NB-1];
    assign ovf       = g_stg[NB-1].g_ovf.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed and random checks of cla_pipe_adder
// against an arithmetic reference model with an in-order scoreboard.
module tb_cla_pipe_adder;

    localparam int W  = 32;
    localparam int BW = 8;
    localparam int NB = W / BW;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         G;
    logic         P;

    cla_pipe_adder #(.WIDTH(W), .BLOCK_W(BW)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .ovf      (ovf),
        .G        (G),
        .P        (P)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        logic         g;
        logic         p;
        int           acc;
    } exp_t;

    exp_t exp_q[$];

    int n_chk      = 0;
    int n_fail     = 0;
    int cyc_n      = 0;
    int n_acc      = 0;
    int n_emit     = 0;
    int last_lat   = 0;
    int first_emit = -1;
    int last_emit  = -1;
    int a0, e0;

    logic [W-1:0] last_sum;
    logic         last_co, last_ov, last_g, last_p;
    logic         in_r;
    logic         r_c, r_s, r_o;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        logic [W-1:0] yb;
        logic [W:0]   full;
        logic [W:0]   gen;
        exp_t         e;
        yb   = sb ? ~y : y;
        gen  = {1'b0, x} + {1'b0, yb};
        full = gen + {{W{1'b0}}, ci ^ sb};
        e.s  = full[W-1:0];
        e.co = full[W];
        e.ov = (x[W-1] == yb[W-1]) && (e.s[W-1] != x[W-1]);
        e.g  = gen[W];
        e.p  = ((x ^ yb) == {W{1'b1}});
        e.acc = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called just after a falling edge; samples handshakes before the rising edge.
    task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb, input logic ordy);
        exp_t e;
        in_valid  = v;
        a         = x;
        b         = y;
        c_in      = ci;
        sub       = sb;
        out_ready = ordy;
        #1;
        in_r = in_ready;
        if (out_valid && out_ready) begin
            chk("out_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sum", 64'(sum), 64'(e.s));
                chk("c_out", 64'(c_out), 64'(e.co));
                chk("ovf", 64'(ovf), 64'(e.ov));
                chk("G", 64'(G), 64'(e.g));
                chk("P", 64'(P), 64'(e.p));
                last_lat = cyc_n - e.acc;
                last_sum = sum;
                last_co  = c_out;
                last_ov  = ovf;
                last_g   = G;
                last_p   = P;
                n_emit++;
                if (first_emit < 0) first_emit = cyc_n;
                last_emit = cyc_n;
            end
        end else if (out_valid && exp_q.size() > 0) begin
            chk("hold_sum", 64'(sum), 64'(exp_q[0].s));
        end
        if (v && in_r) begin
            e     = model(x, y, ci, sb);
            e.acc = cyc_n;
            exp_q.push_back(e);
            n_acc++;
        end
        @(posedge clock);
        cyc_n++;
        @(negedge clock);
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || out_valid) && n < maxc) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < NB + 1; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_c_out", 64'(c_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_G", 64'(G), 64'd0);
        chk("rst_P", 64'(P), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);

        step(1'b1, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b1);
        drain(20);
        chk("basic_latency", 64'(last_lat), 64'(NB));
        chk("basic_sum", 64'(last_sum), 64'h8);
        chk("basic_c_out", 64'(last_co), 64'd0);
        chk("basic_ovf", 64'(last_ov), 64'd0);

        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        drain(20);
        chk("ripple_sum", 64'(last_sum), 64'h0);
        chk("ripple_c_out", 64'(last_co), 64'd1);
        chk("ripple_P", 64'(last_p), 64'd1);
        chk("ripple_G", 64'(last_g), 64'd0);

        step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        drain(20);
        chk("ovf_sum", 64'(last_sum), 64'h8000_0000);
        chk("ovf_ovf", 64'(last_ov), 64'd1);
        chk("ovf_c_out", 64'(last_co), 64'd0);

        step(1'b1, 32'd5, 32'd7, 1'b0, 1'b1, 1'b1);
        drain(20);
        chk("sub_neg_sum", 64'(last_sum), 64'hFFFF_FFFE);
        chk("sub_neg_c_out", 64'(last_co), 64'd0);

        step(1'b1, 32'd7, 32'd5, 1'b0, 1'b1, 1'b1);
        drain(20);
        chk("sub_pos_sum", 64'(last_sum), 64'h2);
        chk("sub_pos_c_out", 64'(last_co), 64'd1);
        chk("sub_pos_ovf", 64'(last_ov), 64'd0);

        first_emit = -1;
        e0 = n_emit;
        for (int i = 0; i < 10; i++) begin
            r_c = 1'($urandom);
            r_s = 1'($urandom);
            step(1'b1, $urandom, $urandom, r_c, r_s, 1'b1);
            chk("tp_in_ready", 64'(in_r), 64'd1);
        end
        drain(20);
        chk("tp_count", 64'(n_emit - e0), 64'd10);
        chk("tp_burst", 64'(last_emit - first_emit), 64'd9);

        a0 = n_acc;
        e0 = n_emit;
        for (int i = 0; i < NB + 2; i++) begin
            r_c = 1'($urandom);
            r_s = 1'($urandom);
            step(1'b1, $urandom, $urandom, r_c, r_s, 1'b0);
        end
        chk("bp_accepts", 64'(n_acc - a0), 64'(NB));
        chk("bp_in_ready", 64'(in_r), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        drain(20);
        chk("bp_drained", 64'(n_emit - e0), 64'(NB));

        for (int i = 0; i < 3; i++) begin
            step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
        end
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_c_out", 64'(c_out), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        chk("mid_rst_G", 64'(G), 64'd0);
        chk("mid_rst_P", 64'(P), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        e0 = n_emit;
        for (int i = 0; i < 2 * NB; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_no_out", 64'(n_emit - e0), 64'd0);

        a0 = n_acc;
        e0 = n_emit;
        for (int i = 0; i < 40; i++) begin
            r_c = 1'($urandom);
            r_s = 1'($urandom);
            r_o = 1'($urandom);
            step((i % 2) == 0, $urandom, $urandom, r_c, r_s, r_o);
        end
        drain(40);
        chk("bub_count", 64'(n_emit - e0), 64'(n_acc - a0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath; generalises the existing single-cycle 8-bit CLA block.
- Operand width is split into NB = WIDTH/BLOCK_W lookahead blocks. Each block is computed in its own register stage, and the block carry ripples stage-to-stage.
- Adds add/subtract mode, word-level group generate/propagate, signed overflow and a valid/ready handshake with backpressure.
- One new operation per cycle is accepted at full throughput.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of BLOCK_W.
- BLOCK_W, 8, bits per lookahead block; equals the bits resolved per pipeline stage.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  pipeline can accept; transfer when in_valid && in_ready
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry in
- sub  in  1  1 = subtract
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- sum  out  WIDTH  result
- c_out  out  1  carry out of MSB
- ovf  out  1  signed overflow
- G  out  1  word group generate (carry out assuming carry-in 0)
- P  out  1  word group propagate (AND of all a_i^b'_i)

Behaviour:
- Effective operands and carry:
  - b' = b XOR {WIDTH{sub}}.
  - Effective carry-in = c_in XOR sub.
  - Result: sub=0 gives a+b+c_in; sub=1,c_in=0 gives a-b; sub=1,c_in=1 gives a-b-1.
- Stage layout:
  - NB stages, k = 0..NB-1. Stage k holds a valid bit, the full sum, the carry into block k+1, accumulated G/P and the remaining high operand bits.
  - Stage k computes bits [k*BLOCK_W +: BLOCK_W] with a BLOCK_W-bit CLA. Bit-level g = a&b', p = a^b'.
  - The block's carry-in comes from stage k-1's register; stage 0 uses the effective carry-in.
  - Completed low bits are forwarded unchanged.
- G/P accumulation:
  - G_acc' = G_blk | (P_blk & G_acc).
  - P_acc' = P_acc & P_blk.
  - Stage 0 starts from G_acc=0, P_acc=1.
- Result fields:
  - ovf = carry into MSB XOR c_out, computed in the final stage.
  - Outputs are driven directly from the last stage's registers; no combinational path from inputs.
- Latency: NB cycles from the accepting edge to out_valid (4 at defaults).
- Handshake and flow control:
  - Each stage advances when it is empty or the next stage advances.
  - The last stage advances on out_ready.
  - in_ready = !valid[0] || stage 0 advances. in_ready is combinational from out_ready; this is the only combinational input-to-output path.
  - out_valid and the result stay stable while out_ready=0.
  - Bubbles collapse: an empty downstream stage is filled even when stalled further down.
  - Full backpressure fills all NB stages, after which in_ready=0.
  - Simultaneous accept and emit in the same cycle sustains one op per cycle.
- Reset (asynchronous, reset_n low):
  - All valid bits clear, data registers clear.
  - out_valid=0, sum=0, c_out=0, ovf=0, G=0, P=0.
  - in_ready=1 after release.
  - Reset mid-operation discards all in-flight ops; no partial result ever appears.
- Boundaries:
  - Carry wrap: 0xFFFF_FFFF+1 gives sum=0, c_out=1.
  - Full-word propagate chain: a^b' all ones, carry-in=1 gives P=1, carry ripples through every stage.
  - in_valid=0 inserts a bubble; no output is produced for it.

Test Plan (WIDTH=32, BLOCK_W=8):
- Basic add: a=0x0000_0005, b=0x0000_0003, c_in=0, sub=0, out_ready=1 -> out_valid exactly 4 cycles later, sum=0x0000_0008, c_out=0, ovf=0.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, c_in=1 -> sum=0x0000_0000, c_out=1, P=1, G=0. Then a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, ovf=1, c_out=0.
- Subtract: a=5, b=7, sub=1, c_in=0 -> sum=0xFFFF_FFFE, c_out=0. Then a=7, b=5, sub=1 -> sum=2, c_out=1, ovf=0.
- Throughput and backpressure:
  - 10 back-to-back random ops with out_ready=1 -> one result per cycle, in order, matching the reference model.
  - Hold out_ready=0 -> in_ready falls after 4 accepts and the output holds stable.
  - Release out_ready -> all results drain in order with no loss or duplication.
- Reset mid-flight: accept 3 ops, pulse reset_n low asynchronously between edges -> all outputs 0 immediately, in_ready=1, and none of the 3 results ever emerges.
- Bubbles: alternate in_valid 1/0 with random out_ready -> output count equals accept count, order and values are correct.
